// File: rtl/hdmi_cfg_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_cfg_pkg
// Shared definitions for the HDMI transmitter power-up configuration
// sequencer: the sequencer state encoding, the default 8-bit I2C write
// address of the transmitter and the width of one {register, value} entry.
// ---------------------------------------------------------------------------
package hdmi_cfg_pkg;

   localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h72;
   localparam int         ENTRY_W            = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWR_WAIT,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_CHECK,
      ST_GAP,
      ST_DONE,
      ST_ERROR
   } cfg_state_t;

endpackage

// File: rtl/hdmi_i2c_config_rom.sv
// ---------------------------------------------------------------------------
// hdmi_i2c_config_rom
// Constant register table written to the HDMI transmitter at power-up.
// Each entry is {register address, value}. Indices at or beyond NUM_REGS
// read as zero so a short table never exposes stale entries.
//
// Ports:
//   index  in   8   table index
//   entry  out  16  {reg_addr, value} for that index
// ---------------------------------------------------------------------------
module hdmi_i2c_config_rom
   import hdmi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic [7:0]         index,
   output logic [ENTRY_W-1:0] entry
);

   localparam logic [8:0] NUM_ENTRIES = 9'(NUM_REGS);

   logic [ENTRY_W-1:0] table_value;

   // Register list for an ADV-style transmitter: power-up, fixed
   // reserved-register values, video input format and HDMI mode setup.
   always_comb begin
      table_value = '0;
      case (index)
         8'd0:    table_value = 16'h4110;
         8'd1:    table_value = 16'h9803;
         8'd2:    table_value = 16'h9AE0;
         8'd3:    table_value = 16'h9C30;
         8'd4:    table_value = 16'h9D61;
         8'd5:    table_value = 16'hA2A4;
         8'd6:    table_value = 16'hA3A4;
         8'd7:    table_value = 16'hE0D0;
         8'd8:    table_value = 16'hF900;
         8'd9:    table_value = 16'h1500;
         8'd10:   table_value = 16'h1630;
         8'd11:   table_value = 16'h1702;
         8'd12:   table_value = 16'h1846;
         8'd13:   table_value = 16'h4080;
         8'd14:   table_value = 16'h4808;
         8'd15:   table_value = 16'h49A8;
         8'd16:   table_value = 16'h4C00;
         8'd17:   table_value = 16'h5500;
         8'd18:   table_value = 16'h5608;
         8'd19:   table_value = 16'h9620;
         8'd20:   table_value = 16'hAF06;
         8'd21:   table_value = 16'hBA60;
         8'd22:   table_value = 16'hD03C;
         8'd23:   table_value = 16'hD1FF;
         8'd24:   table_value = 16'hDE9C;
         8'd25:   table_value = 16'hE460;
         8'd26:   table_value = 16'hFA7D;
         8'd27:   table_value = 16'h3B80;
         8'd28:   table_value = 16'h3C10;
         8'd29:   table_value = 16'h0A01;
         8'd30:   table_value = 16'h0C00;
         8'd31:   table_value = 16'hD6C0;
         default: table_value = '0;
      endcase
   end

   // Mask entries past the configured table length.
   always_comb begin
      entry = '0;
      if ({1'b0, index} < NUM_ENTRIES) begin
         entry = table_value;
      end
   end

endmodule

// File: rtl/hdmi_i2c_config_seq.sv
// ---------------------------------------------------------------------------
// hdmi_i2c_config_seq
// Power-up configuration sequencer for the HDMI transmitter's I2C bus.
// After go rises it waits POWERUP_CYCLES, then writes every table entry as
// one 3-byte I2C write, retrying NACKed writes up to RETRY_MAX times and
// giving up on a transaction that takes longer than TIMEOUT_CYCLES.
//
// Optional build macro HDMI_CFG_HPD_RETRIGGER_EN adds input hpd: a rising
// hot-plug edge in DONE or ERROR (with go still high) restarts the run.
//
// Ports:
//   clock_100khz   in   1   system clock, shared with the I2C controller
//   reset_n        in   1   asynchronous active-low reset
//   go             in   1   level, starts a run from IDLE, low aborts
//   i2c_stop       in   1   low pulse = controller finished a transaction
//   i2c_ack        in   1   high = acknowledge slot sampled as NACK
//   hpd            in   1   (macro only) synchronised hot-plug detect
//   start          out  1   one-cycle launch pulse to the controller
//   slave_address  out  8   constant SLAVE_ADDR
//   register_data  out  16  {reg_addr, value} of the current write
//   busy           out  1   run in progress
//   config_done    out  1   every entry acknowledged
//   config_error   out  1   retries exhausted or transaction timeout
//   error_index    out  8   failing table index while config_error=1
// ---------------------------------------------------------------------------
module hdmi_i2c_config_seq
   import hdmi_cfg_pkg::*;
#(
   parameter int         NUM_REGS       = 32,
   parameter logic [7:0] SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
   parameter int         POWERUP_CYCLES = 20000,
   parameter int         GAP_CYCLES     = 4,
   parameter int         RETRY_MAX      = 3,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic               clock_100khz,
   input  logic               reset_n,
   input  logic               go,
   input  logic               i2c_stop,
   input  logic               i2c_ack,
`ifdef HDMI_CFG_HPD_RETRIGGER_EN
   input  logic               hpd,
`endif
   output logic               start,
   output logic [7:0]         slave_address,
   output logic [ENTRY_W-1:0] register_data,
   output logic               busy,
   output logic               config_done,
   output logic               config_error,
   output logic [7:0]         error_index
);

   localparam logic [7:0]  LAST_INDEX    = 8'(NUM_REGS - 1);
   localparam logic [15:0] POWERUP_LOAD  = 16'(POWERUP_CYCLES);
   localparam logic [15:0] GAP_LOAD      = 16'(GAP_CYCLES);
   localparam logic [3:0]  RETRY_LIMIT   = 4'(RETRY_MAX);
   localparam logic [7:0]  WATCHDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam cfg_state_t  RUN_ENTRY     = (POWERUP_CYCLES == 0) ? ST_LOAD : ST_PWR_WAIT;

   cfg_state_t         state;
   cfg_state_t         next_state;
   logic [7:0]         index;
   logic [3:0]         retry;
   logic [15:0]        timer;
   logic [7:0]         watchdog;
   logic               txn_nack;
   logic               retrigger;
   logic [ENTRY_W-1:0] rom_entry;

   hdmi_i2c_config_rom #(
      .NUM_REGS (NUM_REGS)
   ) u_rom (
      .index (index),
      .entry (rom_entry)
   );

   assign slave_address = SLAVE_ADDR;

`ifdef HDMI_CFG_HPD_RETRIGGER_EN
   logic hpd_q;

   // Delayed copy of hot-plug detect so a fresh plug-in edge can restart
   // a finished or failed run without toggling go.
   always_ff @(posedge clock_100khz or negedge reset_n) begin
      if (!reset_n) begin
         hpd_q <= 1'b0;
      end else begin
         hpd_q <= hpd;
      end
   end

   assign retrigger = go & hpd & ~hpd_q;
`else
   assign retrigger = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock_100khz or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A completion strobe wins over the watchdog in the
   // same cycle, and go is only honoured as an abort at the end of the
   // inter-transaction gap so the bus is never left mid-write.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (go) next_state = RUN_ENTRY;
         end
         ST_PWR_WAIT: begin
            if (timer == 16'd0) next_state = ST_LOAD;
         end
         ST_LOAD:  next_state = ST_START;
         ST_START: next_state = ST_WAIT;
         ST_WAIT: begin
            if (!i2c_stop) begin
               next_state = ST_CHECK;
            end else if (watchdog == WATCHDOG_LAST) begin
               next_state = ST_ERROR;
            end
         end
         ST_CHECK: begin
            if (txn_nack) begin
               next_state = (retry < RETRY_LIMIT) ? ST_GAP : ST_ERROR;
            end else begin
               next_state = (index == LAST_INDEX) ? ST_DONE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (timer <= 16'd1) next_state = go ? ST_LOAD : ST_IDLE;
         end
         ST_DONE, ST_ERROR: begin
            if (!go) begin
               next_state = ST_IDLE;
            end else if (retrigger) begin
               next_state = RUN_ENTRY;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Datapath: table index, retry count, shared power-up/gap timer, the
   // per-transaction watchdog, the sticky NACK flag and the held write data.
   always_ff @(posedge clock_100khz or negedge reset_n) begin
      if (!reset_n) begin
         index         <= 8'd0;
         retry         <= 4'd0;
         timer         <= 16'd0;
         watchdog      <= 8'd0;
         txn_nack      <= 1'b0;
         register_data <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (next_state == RUN_ENTRY) begin
                  index <= 8'd0;
                  retry <= 4'd0;
                  timer <= POWERUP_LOAD;
               end
            end
            ST_PWR_WAIT: begin
               if (timer != 16'd0) timer <= timer - 16'd1;
            end
            ST_LOAD: begin
               register_data <= rom_entry;
            end
            ST_START: begin
               txn_nack <= 1'b0;
               watchdog <= 8'd0;
            end
            ST_WAIT: begin
               txn_nack <= txn_nack | i2c_ack;
               watchdog <= watchdog + 8'd1;
            end
            ST_CHECK: begin
               timer <= GAP_LOAD;
               if (txn_nack) begin
                  if (retry < RETRY_LIMIT) retry <= retry + 4'd1;
               end else begin
                  retry <= 4'd0;
                  if (index != LAST_INDEX) index <= index + 8'd1;
               end
            end
            ST_GAP: begin
               if (timer > 16'd1) timer <= timer - 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode straight from the registered state, so start is a
   // clean single-cycle pulse and the flags follow the state they report.
   always_comb begin
      start        = (state == ST_START);
      busy         = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
      config_done  = (state == ST_DONE);
      config_error = (state == ST_ERROR);
      error_index  = (state == ST_ERROR) ? index : 8'd0;
   end

endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// ---------------------------------------------------------------------------
// tb_hdmi_i2c_config_seq
// Directed testbench for the HDMI I2C configuration sequencer with a short
// three-entry table and a 10-cycle power-up wait. A small behavioural I2C
// controller answers each start pulse and can NACK selected entries or
// never finish, and every observation is an immediate assertion against a
// hand-computed value.
// ---------------------------------------------------------------------------
module tb_hdmi_i2c_config_seq;

   logic        clock_100khz;
   logic        reset_n;
   logic        go;
   logic        i2c_stop;
   logic        i2c_ack;
   logic        hpd;
   logic        start;
   logic [7:0]  slave_address;
   logic [15:0] register_data;
   logic        busy;
   logic        config_done;
   logic        config_error;
   logic [7:0]  error_index;

   int          tests_run;
   int          tests_failed;
   int          cycle;
   int          start_count;
   int          start_cycle;
   int          end_cycle;
   logic [15:0] data_log[$];
   int          nack_once[3];
   bit          nack_always[3];
   bit          never_stop;

   hdmi_i2c_config_seq #(
      .NUM_REGS       (3),
      .SLAVE_ADDR     (8'h72),
      .POWERUP_CYCLES (10),
      .GAP_CYCLES     (4),
      .RETRY_MAX      (3),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clock_100khz  (clock_100khz),
      .reset_n       (reset_n),
      .go            (go),
      .i2c_stop      (i2c_stop),
      .i2c_ack       (i2c_ack),
`ifdef HDMI_CFG_HPD_RETRIGGER_EN
      .hpd           (hpd),
`endif
      .start         (start),
      .slave_address (slave_address),
      .register_data (register_data),
      .busy          (busy),
      .config_done   (config_done),
      .config_error  (config_error),
      .error_index   (error_index)
   );

   // Free-running clock and a cycle counter used to time the watchdog.
   initial clock_100khz = 1'b0;
   always #5 clock_100khz = ~clock_100khz;

   always @(posedge clock_100khz) cycle <= cycle + 1;

   // Map a written word back to its table position (first three entries).
   function automatic int entryOf(input logic [15:0] data);
      case (data)
         16'h4110: return 0;
         16'h9803: return 1;
         16'h9AE0: return 2;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [15:0] logAt(input int i);
      if (i < data_log.size()) return data_log[i];
      return 16'hDEAD;
   endfunction

   // Behavioural I2C byte-write controller: logs every launched write,
   // optionally raises the NACK flag mid-transaction, then pulses stop low.
   initial begin : controller_model
      int   idx;
      logic nack;
      i2c_stop = 1'b1;
      i2c_ack  = 1'b0;
      forever begin
         @(negedge clock_100khz);
         if (start === 1'b1) begin
            start_count++;
            start_cycle = cycle;
            data_log.push_back(register_data);
            idx  = entryOf(register_data);
            nack = 1'b0;
            if (idx >= 0) begin
               if (nack_always[idx]) begin
                  nack = 1'b1;
               end else if (nack_once[idx] > 0) begin
                  nack = 1'b1;
                  nack_once[idx]--;
               end
            end
            repeat (2) @(negedge clock_100khz);
            if (nack) i2c_ack = 1'b1;
            @(negedge clock_100khz);
            i2c_ack = 1'b0;
            if (!never_stop) begin
               i2c_stop = 1'b0;
               @(negedge clock_100khz);
               i2c_stop = 1'b1;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic go_value);
      @(negedge clock_100khz);
      go = go_value;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clock_100khz);
      #1;
   endtask

   task automatic clearModel();
      start_count = 0;
      data_log.delete();
      never_stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nack_once[i]   = 0;
         nack_always[i] = 1'b0;
      end
   endtask

   // Wait, bounded, for the run to land in DONE or ERROR.
   task automatic waitForEnd(input string tag, input int budget);
      int   n;
      logic ended;
      n = 0;
      @(negedge clock_100khz);
      #1;
      while (!(config_done || config_error) && n < budget) begin
         @(negedge clock_100khz);
         #1;
         n++;
      end
      end_cycle = cycle;
      ended = config_done | config_error;
      checkOutput(tag, {31'd0, ended}, 32'd1);
   endtask

   // Wait, bounded, until the model has seen the given number of starts.
   task automatic waitForStarts(input string tag, input int count, input int budget);
      int n;
      n = 0;
      while (start_count < count && n < budget) begin
         @(negedge clock_100khz);
         #1;
         n++;
      end
      checkOutput(tag, start_count, count);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      cycle        = 0;
      start_cycle  = 0;
      end_cycle    = 0;
      go           = 1'b0;
      hpd          = 1'b0;
      reset_n      = 1'b0;
      clearModel();

      // Reset state.
      idleCycles(3);
      checkOutput("reset_start", start, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_data", register_data, 0);
      checkOutput("reset_done", config_done, 0);
      checkOutput("reset_error", config_error, 0);
      checkOutput("reset_error_index", error_index, 0);
      checkOutput("slave_address", slave_address, 32'h72);
      @(negedge clock_100khz);
      reset_n = 1'b1;
      idleCycles(2);

      // 1: all three entries acknowledged in order.
      $display("[TB] test 1: clean run");
      clearModel();
      applyStimulus(1'b1);
      idleCycles(3);
      checkOutput("t1_busy_running", busy, 1);
      waitForEnd("t1_finished", 2000);
      checkOutput("t1_done", config_done, 1);
      checkOutput("t1_error", config_error, 0);
      checkOutput("t1_busy_after", busy, 0);
      checkOutput("t1_starts", start_count, 3);
      checkOutput("t1_entry0", logAt(0), 32'h4110);
      checkOutput("t1_entry1", logAt(1), 32'h9803);
      checkOutput("t1_entry2", logAt(2), 32'h9AE0);
      applyStimulus(1'b0);
      idleCycles(2);
      checkOutput("t1_done_cleared", config_done, 0);

      // 2: entry 1 NACKed once, retried and accepted.
      $display("[TB] test 2: single NACK on entry 1");
      clearModel();
      nack_once[1] = 1;
      applyStimulus(1'b1);
      waitForEnd("t2_finished", 2000);
      checkOutput("t2_done", config_done, 1);
      checkOutput("t2_error", config_error, 0);
      checkOutput("t2_starts", start_count, 4);
      checkOutput("t2_write1", logAt(1), 32'h9803);
      checkOutput("t2_write2", logAt(2), 32'h9803);
      checkOutput("t2_write3", logAt(3), 32'h9AE0);
      applyStimulus(1'b0);
      idleCycles(2);

      // 3: entry 2 always NACKed -> four attempts then error at index 2.
      $display("[TB] test 3: persistent NACK on entry 2");
      clearModel();
      nack_always[2] = 1'b1;
      applyStimulus(1'b1);
      waitForEnd("t3_finished", 2000);
      checkOutput("t3_error", config_error, 1);
      checkOutput("t3_done", config_done, 0);
      checkOutput("t3_error_index", error_index, 2);
      checkOutput("t3_starts", start_count, 6);
      checkOutput("t3_last_write", logAt(5), 32'h9AE0);
      checkOutput("t3_busy", busy, 0);
      applyStimulus(1'b0);
      idleCycles(2);
      checkOutput("t3_error_cleared", config_error, 0);
      checkOutput("t3_index_cleared", error_index, 0);

      // 4: controller never completes -> watchdog error on entry 0.
      $display("[TB] test 4: transaction timeout");
      clearModel();
      never_stop = 1'b1;
      applyStimulus(1'b1);
      waitForEnd("t4_finished", 1000);
      checkOutput("t4_error", config_error, 1);
      checkOutput("t4_error_index", error_index, 0);
      checkOutput("t4_starts", start_count, 1);
      checkOutput("t4_start_to_error", end_cycle - start_cycle, 256);
      applyStimulus(1'b0);
      idleCycles(4);
      never_stop = 1'b0;

      // 5: asynchronous reset in the middle of entry 1, then a fresh run.
      $display("[TB] test 5: reset during WAIT");
      clearModel();
      applyStimulus(1'b1);
      waitForStarts("t5_reached_entry1", 2, 500);
      @(negedge clock_100khz);
      reset_n = 1'b0;
      go      = 1'b0;
      #1;
      checkOutput("t5_busy_in_reset", busy, 0);
      checkOutput("t5_data_in_reset", register_data, 0);
      checkOutput("t5_start_in_reset", start, 0);
      idleCycles(8);
      checkOutput("t5_no_start_held", start_count, 2);
      @(negedge clock_100khz);
      reset_n = 1'b1;
      idleCycles(3);
      clearModel();
      applyStimulus(1'b1);
      waitForEnd("t5_finished", 2000);
      checkOutput("t5_restart_entry0", logAt(0), 32'h4110);
      checkOutput("t5_done", config_done, 1);
      checkOutput("t5_starts", start_count, 3);
      applyStimulus(1'b0);
      idleCycles(2);

      // 6: go dropped while entry 0 is in flight -> clean abort.
      $display("[TB] test 6: abort during WAIT");
      clearModel();
      applyStimulus(1'b1);
      waitForStarts("t6_reached_entry0", 1, 500);
      applyStimulus(1'b0);
      idleCycles(40);
      checkOutput("t6_starts", start_count, 1);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_done", config_done, 0);
      checkOutput("t6_error", config_error, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
